// File: rtl/waveform_capture.sv
// Triggered ring-buffer capture: PRE samples before the trigger plus the rest of a DEPTH window.
// Registered readout, one sample per rd_en with 1-cycle latency; no backpressure on ADC_IN.
module waveform_capture #(
  parameter int ADDR_W = 10,
  parameter int PRE    = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] ADC_IN,
  input  logic        trigger,
  input  logic        arm,
  input  logic        rd_en,
  output logic [13:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        data_ready,
  output logic        busy,
  output logic [15:0] trig_count
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE - 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE);
  localparam logic [ADDR_W:0]   RD_FINAL  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, READOUT} state_t;

  state_t            state, state_nxt;
  logic [13:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, cnt, trig_addr, rd_addr;
  logic [ADDR_W:0]   rd_cnt;
  logic              wr_en, trig_hit, rd_issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    trig_hit  = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      IDLE: if (arm) state_nxt = PREFILL;
      PREFILL: begin
        wr_en = 1'b1;
        if (cnt == PRE_LAST) state_nxt = ARMED;
      end
      ARMED: begin
        wr_en = 1'b1;
        if (trigger) begin
          trig_hit  = 1'b1;
          state_nxt = POST;
        end
      end
      POST: begin
        wr_en = 1'b1;
        if (cnt == POST_LAST) state_nxt = READOUT;
      end
      READOUT: begin
        rd_issue = rd_en && (rd_cnt <= RD_FINAL);
        // Leaving on the final issue lines IDLE up with the registered rd_last.
        if (rd_issue && rd_cnt == RD_FINAL) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= ADC_IN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      trig_addr  <= '0;
      trig_count <= '0;
      rd_addr    <= '0;
      rd_cnt     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      if (state == IDLE && arm) begin
        wr_ptr <= '0;
        cnt    <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        cnt    <= trig_hit ? '0 : cnt + 1'b1;
      end
      if (trig_hit) begin
        trig_addr  <= wr_ptr;
        trig_count <= trig_count + 16'd1;
      end
      if (state == POST && state_nxt == READOUT) begin
        rd_addr <= trig_addr - PRE_OFS;
        rd_cnt  <= '0;
      end else if (rd_issue) begin
        rd_addr <= rd_addr + 1'b1;
        rd_cnt  <= rd_cnt + 1'b1;
      end
      rd_valid <= rd_issue;
      rd_last  <= rd_issue && (rd_cnt == RD_FINAL);
      if (rd_issue) rd_data <= mem[rd_addr];
    end
  end

  assign busy       = (state == PREFILL) || (state == ARMED) || (state == POST);
  assign data_ready = (state == READOUT);

endmodule
